// File: rtl/space_wire_tx_packet_feeder_pkg.sv
// Shared constants and types for the SpaceWire TX packet feeder.
// End-marker codes, FSM state encoding and the saturating statistic helper.
package space_wire_pkg;

  localparam logic [7:0] SPW_EOP = 8'h00;
  localparam logic [7:0] SPW_EEP = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_TRUNC = 2'd2,
    ST_FLUSH = 2'd3
  } feeder_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

endpackage

// File: rtl/space_wire_tx_packet_feeder.sv
// Drains a show-ahead FIFO of 9-bit SpaceWire characters into the link TX handshake,
// truncating over-long packets with EEP and flushing to the next end marker after an abort.
module space_wire_tx_packet_feeder
  import space_wire_pkg::*;
#(
  parameter logic [15:0] C_MAX_PKT_LEN = 16'd1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_link_running,
  input  logic        i_fifo_empty,
  input  logic [8:0]  i_fifo_data,
  output logic        o_fifo_rden,
  output logic        o_tx_data_en,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_data_control_flag,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic [15:0] o_pkt_count,
  output logic [7:0]  o_abort_count
);

  localparam int CW = $clog2(int'(C_MAX_PKT_LEN) + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(C_MAX_PKT_LEN);

  feeder_state_t state_r;
  logic [8:0]    hold_r;
  logic          tx_en_r;
  logic [CW-1:0] byte_cnt_r;
  logic [15:0]   pkt_count_r;
  logic [7:0]    abort_count_r;

  logic          xfer_s;
  logic          load_ok_s;
  logic [CW-1:0] cnt_after_s;
  logic          trunc_s;
  logic          rden_s;

  // Pop decision must be combinational: the FIFO is show-ahead and the head is consumed this cycle.
  always_comb begin
    xfer_s      = tx_en_r & i_tx_ready;
    load_ok_s   = ~i_fifo_empty & i_link_running;
    cnt_after_s = byte_cnt_r;
    if (state_r == ST_SEND && xfer_s) begin
      if (hold_r[8]) begin
        cnt_after_s = '0;
      end else begin
        cnt_after_s = byte_cnt_r + CW'(1);
      end
    end else begin
      cnt_after_s = byte_cnt_r;
    end
    // A data head with the packet already at its limit is truncated instead of popped.
    trunc_s = load_ok_s & ~i_fifo_data[8] & (cnt_after_s == MAX_CNT);
    rden_s  = 1'b0;
    case (state_r)
      ST_IDLE:  rden_s = load_ok_s & ~trunc_s;
      ST_SEND:  rden_s = xfer_s & load_ok_s & ~trunc_s;
      ST_TRUNC: rden_s = 1'b0;
      ST_FLUSH: rden_s = ~i_fifo_empty;
      default:  rden_s = 1'b0;
    endcase
    if (i_reset) begin
      rden_s = 1'b0;
    end else begin
      rden_s = rden_s;
    end
  end

  // Framing FSM, holding register and statistics.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r       <= ST_IDLE;
      hold_r        <= 9'h000;
      tx_en_r       <= 1'b0;
      byte_cnt_r    <= '0;
      pkt_count_r   <= 16'd0;
      abort_count_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (byte_cnt_r != '0 && !i_link_running) begin
            abort_count_r <= sat_inc8(abort_count_r);
            byte_cnt_r    <= '0;
            state_r       <= ST_FLUSH;
          end else if (rden_s) begin
            hold_r  <= i_fifo_data;
            tx_en_r <= 1'b1;
            state_r <= ST_SEND;
          end else if (trunc_s) begin
            hold_r  <= {1'b1, SPW_EEP};
            tx_en_r <= 1'b1;
            state_r <= ST_TRUNC;
          end
        end
        ST_SEND: begin
          if (xfer_s) begin
            byte_cnt_r <= cnt_after_s;
            if (hold_r[8] && hold_r[7:0] == SPW_EOP) begin
              pkt_count_r <= pkt_count_r + 16'd1;
            end
            if (rden_s) begin
              hold_r <= i_fifo_data;
            end else if (trunc_s) begin
              hold_r  <= {1'b1, SPW_EEP};
              state_r <= ST_TRUNC;
            end else begin
              hold_r  <= 9'h000;
              tx_en_r <= 1'b0;
              state_r <= ST_IDLE;
            end
          end else if (!i_link_running) begin
            // Unsent character is dropped; an end marker needs no flush behind it.
            hold_r        <= 9'h000;
            tx_en_r       <= 1'b0;
            abort_count_r <= sat_inc8(abort_count_r);
            byte_cnt_r    <= '0;
            state_r       <= hold_r[8] ? ST_IDLE : ST_FLUSH;
          end
        end
        ST_TRUNC: begin
          if (xfer_s || !i_link_running) begin
            hold_r        <= 9'h000;
            tx_en_r       <= 1'b0;
            abort_count_r <= sat_inc8(abort_count_r);
            byte_cnt_r    <= '0;
            state_r       <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!i_fifo_empty && i_fifo_data[8]) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          hold_r  <= 9'h000;
          tx_en_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_fifo_rden            = rden_s;
  assign o_tx_data_en           = tx_en_r;
  assign o_tx_data              = hold_r[7:0];
  assign o_tx_data_control_flag = hold_r[8];
  assign o_busy                 = (state_r != ST_IDLE) | (byte_cnt_r != '0);
  assign o_pkt_count            = pkt_count_r;
  assign o_abort_count          = abort_count_r;

endmodule

// File: tb/tb_space_wire_tx_packet_feeder.sv
// Directed bench for the TX packet feeder: show-ahead FIFO model, transfer log and per-scenario checks.
module tb_space_wire_tx_packet_feeder;

  logic        clk = 1'b0;
  logic        reset, link_running, fifo_empty, fifo_rden;
  logic [8:0]  fifo_data;
  logic        tx_en, tx_flag, tx_ready, busy;
  logic [7:0]  tx_data, abort_count;
  logic [15:0] pkt_count;

  int total = 0;
  int bad = 0;

  logic [8:0] mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_count = 0;
  logic [8:0] log_q [0:4095];
  int log_cyc [0:4095];
  int log_n = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  space_wire_tx_packet_feeder #(.C_MAX_PKT_LEN(16'd4)) dut (
    .i_clk(clk), .i_reset(reset), .i_link_running(link_running),
    .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data), .o_fifo_rden(fifo_rden),
    .o_tx_data_en(tx_en), .o_tx_data(tx_data), .o_tx_data_control_flag(tx_flag),
    .i_tx_ready(tx_ready), .o_busy(busy), .o_pkt_count(pkt_count), .o_abort_count(abort_count)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[10:0]];

  // FIFO pop side and transfer log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rden && !fifo_empty) begin
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
    if (tx_en && tx_ready && log_n < 4096) begin
      log_q[log_n]   <= {tx_flag, tx_data};
      log_cyc[log_n] <= cyc;
      log_n          <= log_n + 1;
    end
  end

  task automatic push(input logic [8:0] v);
    mem[wr_ptr[10:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fifo_empty && !busy && !tx_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; link_running = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx_en !== 1'b0 || fifo_rden !== 1'b0) begin bad++; $display("FAIL reset_en_rden: got en=%b rden=%b want 0 0", tx_en, fifo_rden); end
    total++; if (tx_data !== 8'h00 || tx_flag !== 1'b0) begin bad++; $display("FAIL reset_data: got %h/%b want 00/0", tx_data, tx_flag); end
    total++; if (pkt_count !== 16'd0 || abort_count !== 8'd0) begin bad++; $display("FAIL reset_counts: got pkt=%0d abort=%0d want 0 0", pkt_count, abort_count); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || tx_en !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b en=%b want 0 0", busy, tx_en); end
  endtask

  task automatic test_basic;
    int base, p0;
    bit ok;
    link_running = 1'b1; tx_ready = 1'b1;
    base = log_n; p0 = pop_count;
    push(9'h0A5); push(9'h03C); push(9'h100);
    #1;
    total++; if (fifo_rden !== 1'b1 || tx_en !== 1'b0) begin bad++; $display("FAIL basic_first_pop: got rden=%b en=%b want 1 0", fifo_rden, tx_en); end
    @(negedge clk);
    total++; if (tx_en !== 1'b1 || tx_data !== 8'hA5 || tx_flag !== 1'b0) begin bad++; $display("FAIL basic_latency: got en=%b data=%h want 1 a5", tx_en, tx_data); end
    wait_idle(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got busy=%b want idle", busy); end
    total++; if (log_n - base !== 3) begin bad++; $display("FAIL basic_xfers: got %0d want 3", log_n - base); end
    total++; if (log_q[base] !== 9'h0A5 || log_q[base+1] !== 9'h03C || log_q[base+2] !== 9'h100) begin bad++; $display("FAIL basic_chars: got %h %h %h want 0a5 03c 100", log_q[base], log_q[base+1], log_q[base+2]); end
    total++; if (log_cyc[base+2] - log_cyc[base] !== 2) begin bad++; $display("FAIL basic_back_to_back: got span %0d want 2", log_cyc[base+2] - log_cyc[base]); end
    total++; if (pkt_count !== 16'd1 || abort_count !== 8'd0 || pop_count - p0 !== 3) begin bad++; $display("FAIL basic_counts: got pkt=%0d abort=%0d pops=%0d want 1 0 3", pkt_count, abort_count, pop_count - p0); end
  endtask

  task automatic test_stall;
    int base, p;
    bit ok, held;
    base = log_n;
    push(9'h0A5); push(9'h03C); push(9'h100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (log_n >= base + 1) break;
    end
    total++; if (log_n - base !== 1) begin bad++; $display("FAIL stall_first: got %0d xfers want 1", log_n - base); end
    tx_ready = 1'b0;
    p = pop_count; held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(tx_en === 1'b1 && tx_data === 8'h3C && tx_flag === 1'b0 && fifo_rden === 1'b0)) held = 1'b0;
    end
    total++; if (!held) begin bad++; $display("FAIL stall_hold: got en=%b data=%h want 1 3c held", tx_en, tx_data); end
    total++; if (pop_count !== p || log_n - base !== 1) begin bad++; $display("FAIL stall_pops: got pops=%0d xfers=%0d want %0d 1", pop_count, log_n - base, p); end
    tx_ready = 1'b1;
    wait_idle(20, ok);
    total++; if (!ok || log_n - base !== 3 || log_q[base+1] !== 9'h03C || log_q[base+2] !== 9'h100) begin bad++; $display("FAIL stall_resume: got xfers=%0d last=%h want 3 100", log_n - base, log_q[base+2]); end
    total++; if (pkt_count !== 16'd2) begin bad++; $display("FAIL stall_pkt: got %0d want 2", pkt_count); end
  endtask

  task automatic test_trunc;
    int base, p0;
    bit ok;
    base = log_n; p0 = pop_count;
    for (int i = 0; i < 6; i++) push(9'h011 + 9'(i));
    push(9'h100);
    wait_idle(40, ok);
    total++; if (!ok || log_n - base !== 5) begin bad++; $display("FAIL trunc_xfers: got %0d want 5", log_n - base); end
    total++; if (log_q[base] !== 9'h011 || log_q[base+3] !== 9'h014 || log_q[base+4] !== 9'h101) begin bad++; $display("FAIL trunc_chars: got %h %h %h want 011 014 101", log_q[base], log_q[base+3], log_q[base+4]); end
    total++; if (abort_count !== 8'd1 || pkt_count !== 16'd2 || pop_count - p0 !== 7) begin bad++; $display("FAIL trunc_counts: got abort=%0d pkt=%0d pops=%0d want 1 2 7", abort_count, pkt_count, pop_count - p0); end
  endtask

  task automatic test_exact;
    int base;
    bit ok;
    base = log_n;
    for (int i = 0; i < 4; i++) push(9'h041 + 9'(i));
    push(9'h100);
    wait_idle(30, ok);
    total++; if (!ok || log_n - base !== 5 || log_q[base+3] !== 9'h044 || log_q[base+4] !== 9'h100) begin bad++; $display("FAIL exact_chars: got n=%0d last=%h want 5 100", log_n - base, log_q[base+4]); end
    total++; if (abort_count !== 8'd1 || pkt_count !== 16'd3) begin bad++; $display("FAIL exact_counts: got abort=%0d pkt=%0d want 1 3", abort_count, pkt_count); end
  endtask

  task automatic test_link_loss;
    int base, p0;
    bit ok;
    base = log_n; p0 = pop_count;
    for (int i = 0; i < 5; i++) push(9'h021 + 9'(i));
    push(9'h100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (log_n >= base + 2) break;
    end
    link_running = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    total++; if (tx_en !== 1'b0 || abort_count !== 8'd2) begin bad++; $display("FAIL loss_drop: got en=%b abort=%0d want 0 2", tx_en, abort_count); end
    wait_idle(20, ok);
    total++; if (!ok || log_n - base !== 2 || pop_count - p0 !== 6) begin bad++; $display("FAIL loss_flush: got xfers=%0d pops=%0d want 2 6", log_n - base, pop_count - p0); end
    total++; if (pkt_count !== 16'd3 || abort_count !== 8'd2) begin bad++; $display("FAIL loss_counts: got pkt=%0d abort=%0d want 3 2", pkt_count, abort_count); end
    link_running = 1'b1; tx_ready = 1'b1;
    base = log_n;
    push(9'h031); push(9'h032); push(9'h100);
    wait_idle(20, ok);
    total++; if (!ok || log_n - base !== 3 || log_q[base] !== 9'h031 || log_q[base+2] !== 9'h100 || pkt_count !== 16'd4) begin bad++; $display("FAIL loss_recover: got n=%0d first=%h pkt=%0d want 3 031 4", log_n - base, log_q[base], pkt_count); end
  endtask

  task automatic test_saturate;
    bit ok;
    int tout;
    logic [7:0] mid;
    tout = 0; mid = 8'd0;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 5; i++) push(9'h051 + 9'(i));
      push(9'h100);
      wait_idle(40, ok);
      if (!ok) tout++;
      if (k == 99) mid = abort_count;
    end
    total++; if (tout !== 0) begin bad++; $display("FAIL sat_timeout: got %0d timeouts want 0", tout); end
    total++; if (mid !== 8'd102) begin bad++; $display("FAIL sat_mid: got %0d want 102", mid); end
    total++; if (abort_count !== 8'hFF || pkt_count !== 16'd4) begin bad++; $display("FAIL sat_final: got abort=%h pkt=%0d want ff 4", abort_count, pkt_count); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    tx_ready = 1'b0; seen = 1'b0;
    push(9'h061); push(9'h062); push(9'h100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_en) begin seen = 1'b1; break; end
    end
    total++; if (!seen || tx_data !== 8'h61) begin bad++; $display("FAIL rmid_send: got en=%b data=%h want 1 61", tx_en, tx_data); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (tx_en !== 1'b0 || fifo_rden !== 1'b0 || tx_data !== 8'h00 || tx_flag !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_outputs: got en=%b rden=%b data=%h busy=%b want 0 0 00 0", tx_en, fifo_rden, tx_data, busy); end
    total++; if (pkt_count !== 16'd0 || abort_count !== 8'd0) begin bad++; $display("FAIL rmid_counts: got pkt=%0d abort=%0d want 0 0", pkt_count, abort_count); end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; link_running = 1'b0; tx_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_trunc();
    test_exact();
    test_link_loss();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
